// File: rtl/rv32_issue_scoreboard.sv
// rv32_issue_scoreboard: decode-stage issue scheduler.
// Tracks in-flight writes from multi-cycle units (MEM, MUL, GRNG) with one
// countdown per architectural register, and stalls decode on RAW, WAW and
// GRNG occupancy hazards.
// Optional feature macro: RV32_SB_FORWARDING_EN. When it is defined, results
// are consumed on the bypass path, so WB_DELAY is not added to latencies and
// ALU results never mark a register busy.
module rv32_issue_scoreboard #(
  parameter int LAT_MEM  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_GRNG = 4,
  parameter int GRNG_OCC = 4,
  parameter int WB_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_use_rs,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_register_wb,
  input  logic [1:0]  id_lat_class,
  input  logic        id_grng_use,
  input  logic        pipe_hold,
  input  logic        flush,
  output logic        id_stall,
  output logic        issue,
  output logic [31:0] busy_vec,
  output logic        grng_busy
);

`ifdef RV32_SB_FORWARDING_EN
  localparam int LAT_ADD = 0;
`else
  localparam int LAT_ADD = WB_DELAY;
`endif

  localparam int MAX_MM  = (LAT_MEM > LAT_MUL) ? LAT_MEM : LAT_MUL;
  localparam int MAX_RAW = (MAX_MM > LAT_GRNG) ? MAX_MM : LAT_GRNG;
  localparam int MAX_L   = MAX_RAW + LAT_ADD;
  localparam int CNT_W   = (MAX_L < 1) ? 1 : $clog2(MAX_L + 1);
  localparam int G_W     = (GRNG_OCC < 1) ? 1 : $clog2(GRNG_OCC + 1);

  logic [CNT_W-1:0] cnt_q [1:31];
  logic [CNT_W-1:0] cnt_d [1:31];
  logic [G_W-1:0]   grng_cnt_q;
  logic [G_W-1:0]   grng_cnt_d;
  logic [CNT_W-1:0] lat_eff;
  logic             raw;
  logic             waw;
  logic             structural;
  logic             hazard;

  // x0 never has an in-flight write, so its busy bit is hard-wired low;
  // this also makes every "index != 0" check implicit in the lookups below.
  assign busy_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_vec[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  assign grng_busy = (grng_cnt_q != '0);

  // Effective latency loaded into the destination counter on issue.
  always_comb begin
    lat_eff = CNT_W'(LAT_ADD);
    case (id_lat_class)
      2'd1:    lat_eff = CNT_W'(LAT_MEM + LAT_ADD);
      2'd2:    lat_eff = CNT_W'(LAT_MUL + LAT_ADD);
      2'd3:    lat_eff = CNT_W'(LAT_GRNG + LAT_ADD);
      default: lat_eff = CNT_W'(LAT_ADD);
    endcase
  end

  // Hazard detection and the issue/stall handshake toward decode and EX.
  // Issue is also blocked while reset is held so nothing leaves decode then.
  always_comb begin
    raw = (id_use_rs[0] & busy_vec[id_rs1]) |
          (id_use_rs[1] & busy_vec[id_rs2]) |
          (id_use_rs[2] & busy_vec[id_rd]);
    waw        = id_register_wb & busy_vec[id_rd];
    structural = id_grng_use & grng_busy;
    hazard     = id_valid & (raw | waw | structural);
    id_stall   = (hazard & ~flush) | pipe_hold;
    issue      = id_valid & ~hazard & ~flush & ~pipe_hold & ~rst;
  end

  // Next-state for all countdowns: load on issue (wins over decrement),
  // otherwise count down to zero; everything frozen under pipe_hold.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!pipe_hold) begin
        if (issue && id_register_wb && (id_rd == 5'(r))) begin
          cnt_d[r] = lat_eff;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
    grng_cnt_d = grng_cnt_q;
    if (!pipe_hold) begin
      if (issue && id_grng_use) begin
        grng_cnt_d = G_W'(GRNG_OCC);
      end else if (grng_cnt_q != '0) begin
        grng_cnt_d = grng_cnt_q - 1'b1;
      end
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      grng_cnt_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      grng_cnt_q <= grng_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// tb_rv32_issue_scoreboard: directed-vector bench for rv32_issue_scoreboard.
// Expected stall counts are derived from the latency parameters and follow
// the RV32_SB_FORWARDING_EN setting of the build.
module tb_rv32_issue_scoreboard;

`ifdef RV32_SB_FORWARDING_EN
  localparam int ADD = 0;
`else
  localparam int ADD = 2;
`endif
  localparam int L_ALU  = ADD;
  localparam int L_MEM  = 2 + ADD;
  localparam int L_MUL  = 3 + ADD;
  localparam int L_GRNG = 4 + ADD;
  localparam int OCC    = 4;

  typedef struct packed {
    logic       v;
    logic [2:0] use_rs;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wb;
    logic [1:0] cls;
    logic       g;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_use_rs;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_register_wb;
  logic [1:0]  id_lat_class;
  logic        id_grng_use;
  logic        pipe_hold;
  logic        flush;
  logic        id_stall;
  logic        issue;
  logic [31:0] busy_vec;
  logic        grng_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_issue_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_use_rs      (id_use_rs),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_register_wb (id_register_wb),
    .id_lat_class   (id_lat_class),
    .id_grng_use    (id_grng_use),
    .pipe_hold      (pipe_hold),
    .flush          (flush),
    .id_stall       (id_stall),
    .issue          (issue),
    .busy_vec       (busy_vec),
    .grng_busy      (grng_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] use_rs, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic wb, input logic [1:0] cls, input logic g);
    instr_t i;
    i.v = 1'b1; i.use_rs = use_rs; i.rs1 = rs1; i.rs2 = rs2;
    i.rd = rd; i.wb = wb; i.cls = cls; i.g = g;
    return i;
  endfunction

  task automatic apply(input instr_t i);
    id_valid = i.v; id_use_rs = i.use_rs; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rd = i.rd; id_register_wb = i.wb; id_lat_class = i.cls; id_grng_use = i.g;
  endtask

  task automatic idle();
    apply('0);
    pipe_hold = 1'b0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer issues at t; consumer must stall n cycles, then issue.
  task automatic dep(input string tag, input instr_t p, input instr_t c, input int n);
    apply(p);
    @(negedge clk);
    chk({tag, "_prod_issue"}, 32'(issue), 32'd1);
    tick();
    apply(c);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 32'(id_stall), 32'd1);
      chk({tag, "_no_issue"}, 32'(issue), 32'd0);
      tick();
    end
    @(negedge clk);
    chk({tag, "_cons_stall"}, 32'(id_stall), 32'd0);
    chk({tag, "_cons_issue"}, 32'(issue), 32'd1);
    tick();
    idle();
    repeat (8) tick();
    $display("txn %s: consumer issued after %0d stall cycles", tag, n);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_grng_busy", 32'(grng_busy), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);
    chk("rst_stall", 32'(id_stall), 32'd0);
    pipe_hold = 1'b1;
    #1;
    chk("rst_stall_hold", 32'(id_stall), 32'd1);
    pipe_hold = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    $display("txn reset: initial state checked");

    // Mid-run asynchronous reset with x5 and GRNG busy.
    apply(mk(3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 2'd3, 1'b1));
    @(negedge clk);
    chk("mr_prod_issue", 32'(issue), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("mr_busy_before", busy_vec, 32'h0000_0020);
    chk("mr_grng_before", 32'(grng_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mr_busy_after", busy_vec, 32'h0);
    chk("mr_grng_after", 32'(grng_busy), 32'd0);
    apply(mk(3'b001, 5'd5, 5'd0, 5'd1, 1'b0, 2'd0, 1'b0));
    #1;
    chk("mr_issue_in_rst", 32'(issue), 32'd0);
    chk("mr_stall_in_rst", 32'(id_stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_cons_issue", 32'(issue), 32'd1);
    chk("mr_cons_stall", 32'(id_stall), 32'd0);
    tick();
    idle();
    tick();
    $display("txn midrun_reset: counters cleared");

    // MUL -> rs1 RAW.
    dep("mul_raw", mk(3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 2'd2, 1'b0),
                   mk(3'b001, 5'd5, 5'd0, 5'd1, 1'b1, 2'd0, 1'b0), L_MUL);
    // ALU -> rs2 RAW.
    dep("alu_raw", mk(3'b000, 5'd0, 5'd0, 5'd6, 1'b1, 2'd0, 1'b0),
                   mk(3'b010, 5'd0, 5'd6, 5'd0, 1'b0, 2'd0, 1'b0), L_ALU);
    // MUL to x0 never makes x0 busy.
    dep("x0", mk(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 2'd2, 1'b0),
              mk(3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0), 0);
    chk("x0_busy_vec", busy_vec, 32'h0);
    // GRNG structural hazard: occupancy, not result latency, governs.
    dep("grng", mk(3'b000, 5'd0, 5'd0, 5'd7, 1'b1, 2'd3, 1'b1),
                mk(3'b000, 5'd0, 5'd0, 5'd8, 1'b1, 2'd3, 1'b1), OCC);
    // WAW on x13.
    dep("waw", mk(3'b000, 5'd0, 5'd0, 5'd13, 1'b1, 2'd2, 1'b0),
               mk(3'b000, 5'd0, 5'd0, 5'd13, 1'b1, 2'd0, 1'b0), L_MUL);
    // rs3 read of the rd field after a load.
    dep("rs3", mk(3'b000, 5'd0, 5'd0, 5'd14, 1'b1, 2'd1, 1'b0),
               mk(3'b100, 5'd0, 5'd0, 5'd14, 1'b0, 2'd0, 1'b0), L_MEM);

    // pipe_hold for 3 cycles during a load countdown on x9.
    apply(mk(3'b000, 5'd0, 5'd0, 5'd9, 1'b1, 2'd1, 1'b0));
    @(negedge clk);
    chk("hold_prod_issue", 32'(issue), 32'd1);
    tick();
    apply(mk(3'b001, 5'd9, 5'd0, 5'd2, 1'b1, 2'd0, 1'b0));
    @(negedge clk);
    chk("hold_stall0", 32'(id_stall), 32'd1);
    tick();
    pipe_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_stall", 32'(id_stall), 32'd1);
      chk("hold_no_issue", 32'(issue), 32'd0);
      chk("hold_busy9", 32'(busy_vec[9]), 32'd1);
      tick();
    end
    pipe_hold = 1'b0;
    for (int k = 0; k < L_MEM - 1; k++) begin
      @(negedge clk);
      chk("hold_tail_stall", 32'(id_stall), 32'd1);
      chk("hold_tail_no_issue", 32'(issue), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("hold_cons_issue", 32'(issue), 32'd1);
    tick();
    idle();
    repeat (8) tick();
    $display("txn pipe_hold: dependent slipped 3 cycles");

    // Flush of a stalled dependent: no issue, no counter load.
    apply(mk(3'b000, 5'd0, 5'd0, 5'd10, 1'b1, 2'd1, 1'b0));
    @(negedge clk);
    chk("fl_prod_issue", 32'(issue), 32'd1);
    tick();
    apply(mk(3'b001, 5'd10, 5'd0, 5'd11, 1'b1, 2'd2, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    chk("fl_stall", 32'(id_stall), 32'd0);
    chk("fl_issue", 32'(issue), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("fl_busy11", 32'(busy_vec[11]), 32'd0);
    chk("fl_busy10", 32'(busy_vec[10]), 32'd1);
    // Flush of a hazard-free ALU write to x12 must not load its counter.
    apply(mk(3'b000, 5'd0, 5'd0, 5'd12, 1'b1, 2'd0, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    chk("fl2_issue", 32'(issue), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("fl2_busy12", 32'(busy_vec[12]), 32'd0);
    repeat (8) tick();
    @(negedge clk);
    chk("end_busy_vec", busy_vec, 32'h0);
    chk("end_grng_busy", 32'(grng_busy), 32'd0);
    $display("txn flush: no issue, no counter load");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
